// File: rtl/sop_pos_sweeper.sv
// sop_pos_sweeper: exhaustive input sweeper and mismatch counter for an
// N-input, two-output combinational block (e.g. SOP and POS forms of one
// function). Drives `vec` through 0..2^N-1, one value per clock, and counts
// the vectors whose outputs mismatch.
// Optional feature macro: SWEEP_EXPECT_EN. When defined, each output is
// compared against its own expected truth table (exp1/exp2). When undefined,
// the two outputs are compared against each other, and exp1/exp2 are ignored.
module sop_pos_sweeper #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               o1_in,
  input  logic               o2_in,
  input  logic [(1<<N)-1:0]  exp1,
  input  logic [(1<<N)-1:0]  exp2,
  output logic [N-1:0]       vec,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N:0]         err_cnt,
  output logic [N-1:0]       first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
  localparam logic [N-1:0] VEC_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [N:0]   err_cnt_q, err_cnt_d;
  logic [N-1:0] first_fail_q, first_fail_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         mismatch_s;

`ifdef SWEEP_EXPECT_EN
  // Per-output comparison against the expected truth tables; both outputs
  // wrong at one vector still count once.
  always_comb begin
    mismatch_s = (o1_in != exp1[vec_q]) || (o2_in != exp2[vec_q]);
  end
`else
  logic unused_exp_s;

  // The truth-table ports exist only for pin compatibility in this build.
  assign unused_exp_s = ^{exp1, exp2};

  // SOP-vs-POS equivalence: the two circuit outputs must agree.
  always_comb begin
    mismatch_s = (o1_in != o2_in);
  end
`endif

  // Next-state, vector, counter and decoded status computation.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SWEEP;
          vec_d        = '0;
          err_cnt_d    = '0;
          first_fail_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SWEEP: begin
        // Circuit outputs are combinational from vec_q, so they are valid
        // at the edge that ends this cycle: no extra pipeline stage.
        if (mismatch_s) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
          if (err_cnt_q == '0) begin
            first_fail_d = vec_q;
          end else begin
            first_fail_d = first_fail_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        // The last vector is held in DONE so it stays visible.
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        vec_d        = '0;
        err_cnt_d    = '0;
        first_fail_d = '0;
      end
    endcase
    busy_d = (state_d == ST_SWEEP);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_cnt_d == '0);
  end

  // State and output registers; reset has priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;

endmodule
